hilo_muldiv_seq: RTL and testbench

Multi-cycle sequencer for the execute stage's HI/LO resource. It accepts one multiply, divide or HI/LO move per request and runs it iteratively: 32-step shift-add multiply or 32-step restoring divide, with signed fix-up. It owns the HI/LO registers and raises a pipeline stall while a result is pending, so the rest of the datapath stays single-cycle.

---
 rtl/hilo_muldiv_if.sv | 19 +
 rtl/hilo_muldiv_seq.sv | 129 ++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply-divide sequencer.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel,
                  input  busy, stall_req, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, cancel,
                  output busy, stall_req, done, div_by_zero, hi, lo);
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Iterative HI/LO sequencer: 32-step shift-add multiply / restoring divide on magnitudes,
// sign fix-up in a final cycle, and a stall request while a result is pending.
module hilo_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // mul: {partial product, multiplier}; div: low half holds dividend/quotient
  logic [WIDTH-1:0]   rem, opb, hi_q, lo_q;
  logic               is_div_q, neg_q, neg_r, done_q, dz_q;

  logic               req, is_mul, is_div, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign req    = (state == S_IDLE) && bus.start && !bus.cancel;
  assign is_mul = (bus.op[2:1] == 2'b00);
  assign is_div = (bus.op[2:1] == 2'b01);
  // op[0] marks the signed flavour of both MULT and DIV
  assign sa     = bus.op[0] & bus.a[WIDTH-1];
  assign sb     = bus.op[0] & bus.b[WIDTH-1];
  assign mag_a  = sa ? -bus.a : bus.a;
  assign mag_b  = sb ? -bus.b : bus.b;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_sh   = {rem, acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};   // bit WIDTH set means the trial subtract borrowed
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req && is_mul)      state_nxt = S_CALC;
        else if (req && is_div) state_nxt = (bus.b == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.cancel)                 state_nxt = S_IDLE;
        else if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = bus.cancel ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.stall_req = (state == S_CALC) || (state == S_FIX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= (state_nxt == S_DONE);
      // only a zero-divisor request jumps straight from IDLE to DONE
      dz_q   <= (state == S_IDLE) && (state_nxt == S_DONE);
      case (state)
        S_IDLE: if (req) begin
          if (bus.op == OP_MTHI) hi_q <= bus.a;
          if (bus.op == OP_MTLO) lo_q <= bus.a;
          if (is_mul || is_div) begin
            cnt      <= '0;
            is_div_q <= is_div;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            opb      <= is_div ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            rem      <= '0;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (!is_div_q) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem              <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
          end
        end
        S_FIX: if (!bus.cancel) begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Bench for hilo_muldiv_seq: directed vector table, multi-cycle corner sequences, and
// random requests checked against an arithmetic model of the HI/LO registers.
module tb_hilo_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(32)) bus();
  hilo_muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result of one request from the register-level view: MULT/DIV via 64-bit arithmetic.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] av, bv,
                                    input logic [31:0] ch, cl,
                                    output logic [31:0] nh, nl, output logic dz, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    nh = ch; nl = cl; dz = 1'b0; lat = 0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd0: begin p = {32'b0, av} * {32'b0, bv}; nh = p[63:32]; nl = p[31:0]; lat = 34; end
      3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; lat = 34; end
      3'd2: if (bv == 0) begin dz = 1'b1; lat = 1; end
            else begin nl = av / bv; nh = av % bv; lat = 34; end
      3'd3: if (bv == 0) begin dz = 1'b1; lat = 1; end
            else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; lat = 34; end
      3'd4: nh = av;
      3'd5: nl = av;
      default: ;
    endcase
  endfunction

  // Called at a negedge; waits for idle, issues one request, returns what was observed.
  task automatic exec(input logic [2:0] o, input logic [31:0] av, bv,
                      output logic [31:0] rh, rl, output logic rdz, output int lat, output int stc);
    int n = 0;
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_wait", {63'b0, bus.busy}, 64'd0);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    lat = 0; stc = 0; rdz = 1'b0;
    if (o < 3'd4) begin
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1) bus.start = 1'b0;
        if (bus.stall_req) stc++;
      end while (!bus.done && lat < 100);
      rdz = bus.div_by_zero;
    end else begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy || bus.done) lat = -1;
    end
    rh = bus.hi; rl = bus.lo;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl, eh, el, av, bv;
    logic [2:0]  o;
    logic        rdz, edz;
    int          lat, stc, elat, dn;

    tbl[0] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    tbl[1] = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    tbl[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    tbl[4] = '{3'd2, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 34};
    tbl[5] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    tbl[6] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    tbl[7] = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    tbl[8] = '{3'd0, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 34};

    rst = 1'b0;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl, rdz, lat, stc);
      chk($sformatf("tbl%0d_hi", i), rh, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), rl, tbl[i].lo);
      chk($sformatf("tbl%0d_dz", i), rdz, tbl[i].dz);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_stall", i), stc, 33);
    end

    // divide by zero leaves preset HI/LO alone and finishes in one cycle
    exec(3'd4, 32'h11, 32'h0, rh, rl, rdz, lat, stc);
    chk("mthi_hi", rh, 32'h11);
    chk("mthi_lat", lat, 0);
    exec(3'd5, 32'h22, 32'h0, rh, rl, rdz, lat, stc);
    chk("mtlo_lo", rl, 32'h22);
    exec(3'd2, 32'h5, 32'h0, rh, rl, rdz, lat, stc);
    chk("dz_lat", lat, 1);
    chk("dz_flag", rdz, 1);
    chk("dz_hi", rh, 32'h11);
    chk("dz_lo", rl, 32'h22);
    @(negedge clk);
    chk("dz_idle", bus.busy, 0);
    chk("dz_done_clr", bus.done, 0);

    // cancel mid-divide; MTLO while busy is dropped
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_mtlo_lo", bus.lo, 32'h22);
    repeat (4) @(negedge clk);
    chk("pre_cancel_busy", bus.busy, 1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_idle", bus.busy, 0);
    dn = 0;
    repeat (40) begin @(negedge clk); if (bus.done) dn++; end
    chk("cancel_nodone", dn, 0);
    chk("cancel_hi", bus.hi, 32'h11);
    chk("cancel_lo", bus.lo, 32'h22);
    exec(3'd5, 32'h5, 32'h0, rh, rl, rdz, lat, stc);
    chk("idle_mtlo_lo", rl, 32'h5);
    bus.cancel = 1'b1;
    exec(3'd4, 32'h99, 32'h0, rh, rl, rdz, lat, stc);
    bus.cancel = 1'b0;
    chk("cancel_mthi_hi", rh, 32'h11);

    // async reset in the middle of a MULT
    exec(3'd4, 32'hDEAD, 32'h0, rh, rl, rdz, lat, stc);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hFFFFFFFD; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_stall", bus.stall_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_stall", bus.stall_req, 0);
    chk("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exec(3'd0, 32'd3, 32'd4, rh, rl, rdz, lat, stc);
    chk("post_rst_lo", rl, 32'd12);
    chk("post_rst_hi", rh, 32'd0);
    chk("post_rst_lat", lat, 34);
    m_hi = 32'd0; m_lo = 32'd12;

    for (int i = 0; i < 50; i++) begin
      o  = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'h0;
        1: bv = 32'hFFFFFFFF;
        2: av = 32'h80000000;
        3: bv = $urandom_range(1, 15);
        default: ;
      endcase
      ref_model(o, av, bv, m_hi, m_lo, eh, el, edz, elat);
      exec(o, av, bv, rh, rl, rdz, lat, stc);
      chk($sformatf("rnd%0d_op%0d_hi", i, o), rh, eh);
      chk($sformatf("rnd%0d_op%0d_lo", i, o), rl, el);
      chk($sformatf("rnd%0d_op%0d_dz", i, o), rdz, edz);
      chk($sformatf("rnd%0d_op%0d_lat", i, o), lat, elat);
      chk($sformatf("rnd%0d_op%0d_stall", i, o), stc, (elat == 34) ? 33 : 0);
      m_hi = eh; m_lo = el;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
